// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg
//   Shared datapath types for the CPU pipeline.
//   word_t     : machine data word
//   regbits_t  : register file index
//   memwb_t    : MEM/WB bundle at default datapath widths
//   memwb_wdat : writeback word selection for a MEM/WB bundle
package cpu_types_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned REG_W  = 5;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [REG_W-1:0]  regbits_t;

    typedef struct packed {
        word_t    npc;
        word_t    rdat;
        word_t    result;
        regbits_t regdest;
        logic     regwen;
        logic     pc2reg;
        logic     mem2reg;
        logic     halt;
    } memwb_t;

    localparam int unsigned MEMWB_W = $bits(memwb_t);

    // pc2reg has priority over mem2reg when both are set.
    function automatic word_t memwb_wdat(input memwb_t b);
        if (b.pc2reg)
            return b.npc;
        else if (b.mem2reg)
            return b.rdat;
        else
            return b.result;
    endfunction

endpackage

// File: rtl/pipeline_memwb_if.sv
// pipeline_memwb_if
//   Port bundle of pipeline_memwb_stage for use by the datapath top.
//   Modport stage : as seen by the MEM/WB register.
//   Modport mem   : as seen by the memory stage (producer).
//   Modport wb    : as seen by writeback (consumer).
interface pipeline_memwb_if
    import cpu_types_pkg::*;
#(
    parameter int unsigned DW = WORD_W,
    parameter int unsigned RW = REG_W
);
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_npc;
    logic [DW-1:0] in_rdat;
    logic [DW-1:0] in_result;
    logic [RW-1:0] in_regdest;
    logic          in_regwen;
    logic          in_pc2reg;
    logic          in_mem2reg;
    logic          in_halt;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_npc;
    logic [DW-1:0] out_rdat;
    logic [DW-1:0] out_result;
    logic [RW-1:0] out_regdest;
    logic          out_regwen;
    logic          out_pc2reg;
    logic          out_mem2reg;
    logic          out_halt;
    logic [DW-1:0] out_wdat;
    logic          halted;

    modport stage (
        input  in_valid, in_npc, in_rdat, in_result, in_regdest, in_regwen,
               in_pc2reg, in_mem2reg, in_halt, flush, out_ready,
        output in_ready, out_valid, out_npc, out_rdat, out_result, out_regdest,
               out_regwen, out_pc2reg, out_mem2reg, out_halt, out_wdat, halted
    );

    modport mem (
        output in_valid, in_npc, in_rdat, in_result, in_regdest, in_regwen,
               in_pc2reg, in_mem2reg, in_halt, flush,
        input  in_ready, halted
    );

    modport wb (
        input  out_valid, out_npc, out_rdat, out_result, out_regdest,
               out_regwen, out_pc2reg, out_mem2reg, out_halt, out_wdat, halted,
        output out_ready
    );

endinterface

// File: rtl/pipe_skid2.sv
// pipe_skid2
//   Generic two-entry skid buffer. The main entry drives the output; the
//   skid entry absorbs one extra item on the first stalled cycle so that
//   in_ready can be registered-only (it depends on skid_valid alone).
//   clk       : clock, all state on rising edge
//   n_rst     : synchronous active-low reset (clears valids and data)
//   flush     : drop both entries and any incoming item at the next edge
//   in_valid  / in_ready  / in_data  : producer side
//   out_valid / out_ready / out_data : consumer side
module pipe_skid2 #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         main_valid;
    logic         skid_valid;
    logic [W-1:0] main_data;
    logic [W-1:0] skid_data;
    logic         accept;
    logic         consume;

    assign in_ready  = ~skid_valid;
    assign out_valid = main_valid;
    assign out_data  = main_data;
    assign accept    = in_valid & in_ready;
    assign consume   = main_valid & out_ready;

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_data  <= '0;
            skid_data  <= '0;
        end else if (flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (consume) begin
            if (skid_valid) begin
                // accept cannot coincide here: in_ready is low while skid is full
                main_data  <= skid_data;
                skid_valid <= 1'b0;
            end else if (accept) begin
                main_data  <= in_data;
            end else begin
                main_valid <= 1'b0;
            end
        end else if (accept) begin
            if (!main_valid) begin
                main_data  <= in_data;
                main_valid <= 1'b1;
            end else begin
                skid_data  <= in_data;
                skid_valid <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/pipeline_memwb_stage.sv
// pipeline_memwb_stage
//   MEM/WB pipeline register with valid/ready handshake, two-entry skid
//   buffer, flush, sticky halt and writeback word selection.
//   CLK, nRST        : clock / synchronous active-low reset
//   in_*             : memory-stage bundle, in_valid/in_ready handshake
//   flush            : discard held and incoming bundles
//   out_*            : registered bundle, out_valid/out_ready handshake
//   out_wdat         : selected writeback word (pc2reg > mem2reg > result)
//   halted           : sticky, set once a HALT bundle has been consumed
module pipeline_memwb_stage
    import cpu_types_pkg::*;
#(
    parameter int unsigned DW = WORD_W,
    parameter int unsigned RW = REG_W
) (
    input  logic          CLK,
    input  logic          nRST,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_npc,
    input  logic [DW-1:0] in_rdat,
    input  logic [DW-1:0] in_result,
    input  logic [RW-1:0] in_regdest,
    input  logic          in_regwen,
    input  logic          in_pc2reg,
    input  logic          in_mem2reg,
    input  logic          in_halt,
    input  logic          flush,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_npc,
    output logic [DW-1:0] out_rdat,
    output logic [DW-1:0] out_result,
    output logic [RW-1:0] out_regdest,
    output logic          out_regwen,
    output logic          out_pc2reg,
    output logic          out_mem2reg,
    output logic          out_halt,
    output logic [DW-1:0] out_wdat,
    output logic          halted
);

    // Same layout as memwb_t, widened to this instance's parameters.
    typedef struct packed {
        logic [DW-1:0] npc;
        logic [DW-1:0] rdat;
        logic [DW-1:0] result;
        logic [RW-1:0] regdest;
        logic          regwen;
        logic          pc2reg;
        logic          mem2reg;
        logic          halt;
    } stage_t;

    localparam int unsigned PW = $bits(stage_t);

    stage_t in_bundle;
    stage_t main_bundle;
    logic   skid_in_ready;
    logic   skid_in_valid;
    logic   halted_q;
    logic   consume;

    always_comb begin
        in_bundle         = '0;
        in_bundle.npc     = in_npc;
        in_bundle.rdat    = in_rdat;
        in_bundle.result  = in_result;
        in_bundle.regdest = in_regdest;
        // r0 is hard-wired zero: never request a write to it
        in_bundle.regwen  = in_regwen & (in_regdest != '0);
        in_bundle.pc2reg  = in_pc2reg;
        in_bundle.mem2reg = in_mem2reg;
        in_bundle.halt    = in_halt;
    end

    assign skid_in_valid = in_valid & ~halted_q;
    assign in_ready      = skid_in_ready & ~halted_q;

    pipe_skid2 #(
        .W (PW)
    ) u_skid (
        .clk       (CLK),
        .n_rst     (nRST),
        .flush     (flush),
        .in_valid  (skid_in_valid),
        .in_ready  (skid_in_ready),
        .in_data   (in_bundle),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (main_bundle)
    );

    assign out_npc     = main_bundle.npc;
    assign out_rdat    = main_bundle.rdat;
    assign out_result  = main_bundle.result;
    assign out_regdest = main_bundle.regdest;
    assign out_regwen  = main_bundle.regwen;
    assign out_pc2reg  = main_bundle.pc2reg;
    assign out_mem2reg = main_bundle.mem2reg;
    assign out_halt    = main_bundle.halt;

    always_comb begin
        if (main_bundle.pc2reg)
            out_wdat = main_bundle.npc;
        else if (main_bundle.mem2reg)
            out_wdat = main_bundle.rdat;
        else
            out_wdat = main_bundle.result;
    end

    // A consume still completes in a flush cycle, so a HALT leaving the
    // stage then must still set halted.
    assign consume = out_valid & out_ready;

    always_ff @(posedge CLK) begin
        if (!nRST)
            halted_q <= 1'b0;
        else if (consume && main_bundle.halt)
            halted_q <= 1'b1;
    end

    assign halted = halted_q;

endmodule
